// File: rtl/reservation_station_cdb_pkg.sv
// Shared types for the reservation station: entry/CDB structs, widths, default depth
// and the operand wakeup rule used on both stored and dispatching entries.
package reservation_station_cdb_pkg;

    localparam int unsigned RS_DEPTH = 8;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ROB_W    = 5;
    localparam int unsigned OP_W     = 8;

    typedef logic [TAG_W-1:0]  ptag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ROB_W-1:0]  rob_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        ptag_t           ps1;
        ptag_t           ps2;
        logic            ps1_rdy;
        logic            ps2_rdy;
        data_t           ps1_val;
        data_t           ps2_val;
        ptag_t           pd;
        rob_t            rob_idx;
    } rs_entry_t;

    typedef struct packed {
        logic  valid;
        ptag_t pd;
        data_t rd_v;
        rob_t  rob_idx;
    } cdb_t;

    // Capture a broadcast into any not-yet-ready source waiting on its tag; tag 0 never broadcasts.
    function automatic rs_entry_t rs_wakeup(rs_entry_t e, cdb_t c);
        rs_entry_t r;
        r = e;
        if (c.valid && (c.pd != '0)) begin
            if (!e.ps1_rdy && (e.ps1 == c.pd)) begin
                r.ps1_rdy = 1'b1;
                r.ps1_val = c.rd_v;
            end
            if (!e.ps2_rdy && (e.ps2 == c.pd)) begin
                r.ps2_rdy = 1'b1;
                r.ps2_val = c.rd_v;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_cdb_age_select.sv
// Oldest-ready picker: grants the requesting entry that no other requester is older than.
// age_older[j][i] set means entry j was dispatched before entry i.
module rs_age_select #(
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH-1:0]            req,
    input  logic [DEPTH-1:0][DEPTH-1:0] age_older,
    output logic [DEPTH-1:0]            grant
);

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            grant[i] = req[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((j != i) && req[j] && age_older[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station_cdb.sv
// Reservation station with CDB wakeup, dispatch-time capture and age-ordered issue.
// Define RS_CDB_WAKEUP_ISSUE_EN to let a CDB wakeup make an entry issuable in the same cycle.
module reservation_station_cdb
    import reservation_station_cdb_pkg::*;
#(
    parameter int unsigned DEPTH = RS_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      disp_valid,
    input  rs_entry_t disp_entry,
    output logic      disp_ready,
    input  cdb_t      cdb_in,
    output logic      iss_valid,
    output rs_entry_t iss_entry,
    input  logic      fu_ready
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    rs_entry_t                   entry_q [DEPTH];
    rs_entry_t                   entry_d [DEPTH];
    rs_entry_t                   entry_w [DEPTH];
    rs_entry_t                   sel_entry [DEPTH];
    rs_entry_t                   disp_w;
    logic [DEPTH-1:0]            free_onehot;
    logic [DEPTH-1:0]            ready_vec;
    logic [DEPTH-1:0]            grant;
    logic                        disp_fire;
    logic                        iss_fire;

    always_comb begin
        disp_ready  = ~&valid_q;
        free_onehot = ~valid_q & (valid_q + DEPTH'(1));
        disp_fire   = disp_valid && disp_ready && !flush;

        disp_w = disp_entry;
        if (disp_entry.ps1 == '0) begin
            disp_w.ps1_rdy = 1'b1;
            disp_w.ps1_val = '0;
        end
        if (disp_entry.ps2 == '0) begin
            disp_w.ps2_rdy = 1'b1;
            disp_w.ps2_val = '0;
        end
        disp_w = rs_wakeup(disp_w, cdb_in);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_w[i] = rs_wakeup(entry_q[i], cdb_in);
`ifdef RS_CDB_WAKEUP_ISSUE_EN
            sel_entry[i] = entry_w[i];
`else
            sel_entry[i] = entry_q[i];
`endif
            ready_vec[i] = valid_q[i] && sel_entry[i].ps1_rdy && sel_entry[i].ps2_rdy;
        end
    end

    rs_age_select #(
        .DEPTH(DEPTH)
    ) u_age_select (
        .req      (ready_vec),
        .age_older(age_q),
        .grant    (grant)
    );

    always_comb begin
        iss_valid = (|grant) && !flush && !rst;
        iss_entry = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                iss_entry = sel_entry[i];
            end
        end
        iss_fire = iss_valid && fu_ready;
    end

    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_w[i];
            if (iss_fire && grant[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (disp_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (free_onehot[i]) begin
                    entry_d[i] = disp_w;
                    valid_d[i] = 1'b1;
                    // New entry is younger than everything currently held, issuing ones included.
                    for (int unsigned j = 0; j < DEPTH; j++) begin
                        age_d[i][j] = 1'b0;
                        age_d[j][i] = valid_q[j];
                    end
                end
            end
        end
        if (flush) begin
            valid_d = '0;
            age_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_reservation_station_cdb.sv
// Self-checking bench: directed scenarios plus randomized traffic against an age-ordered queue model.
module tb_reservation_station_cdb;
    import reservation_station_cdb_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic      clk = 1'b0;
    logic      rst, flush, disp_valid, fu_ready, disp_ready, iss_valid;
    rs_entry_t disp_entry, iss_entry;
    cdb_t      cdb_in;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    rs_entry_t mq[$];

    reservation_station_cdb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_entry(disp_entry), .disp_ready(disp_ready),
        .cdb_in(cdb_in), .iss_valid(iss_valid), .iss_entry(iss_entry), .fu_ready(fu_ready)
    );

    always #5 clk = ~clk;

    function automatic rs_entry_t tb_wake(rs_entry_t e);
        rs_entry_t r;
        r = e;
        if (cdb_in.valid && cdb_in.pd != 0) begin
            if (!r.ps1_rdy && r.ps1 == cdb_in.pd) begin r.ps1_rdy = 1'b1; r.ps1_val = cdb_in.rd_v; end
            if (!r.ps2_rdy && r.ps2 == cdb_in.pd) begin r.ps2_rdy = 1'b1; r.ps2_val = cdb_in.rd_v; end
        end
        return r;
    endfunction

    function automatic rs_entry_t tb_dispatch_form(rs_entry_t e);
        rs_entry_t r;
        r = e;
        if (r.ps1 == 0) begin r.ps1_rdy = 1'b1; r.ps1_val = 0; end
        if (r.ps2 == 0) begin r.ps2_rdy = 1'b1; r.ps2_val = 0; end
        return tb_wake(r);
    endfunction

    // Oldest entry (front of queue) whose operands are both available this cycle.
    function automatic void model_expect(output logic ev, output rs_entry_t ee, output int idx);
        rs_entry_t cand;
        ev = 1'b0; ee = '0; idx = -1;
        if (!rst && !flush) begin
            for (int i = 0; i < mq.size(); i++) begin
                cand = mq[i];
`ifdef RS_CDB_WAKEUP_ISSUE_EN
                cand = tb_wake(cand);
`endif
                if (cand.ps1_rdy && cand.ps2_rdy) begin
                    ev = 1'b1; ee = cand; idx = i;
                    break;
                end
            end
        end
    endfunction

    function automatic rs_entry_t mk(logic [7:0] op, ptag_t s1, logic r1, data_t v1,
                                     ptag_t s2, logic r2, data_t v2);
        rs_entry_t e;
        e.op = op; e.ps1 = s1; e.ps1_rdy = r1; e.ps1_val = v1;
        e.ps2 = s2; e.ps2_rdy = r2; e.ps2_val = v2;
        e.pd = ptag_t'($urandom_range(1, 63));
        e.rob_idx = rob_t'($urandom);
        return e;
    endfunction

    // Advance one clock and move the model along with it; called at negedge with inputs settled.
    task automatic step();
        logic ev; rs_entry_t ee; int idx; int unsigned sz;
        model_expect(ev, ee, idx);
        sz = mq.size();
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) mq[i] = tb_wake(mq[i]);
            if (ev && fu_ready) mq.delete(idx);
            if (disp_valid && sz < DEPTH) mq.push_back(tb_dispatch_form(disp_entry));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; fu_ready = 1'b0;
        disp_entry = '0; cdb_in = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; disp_valid = 1'b1;
        disp_entry = mk(8'h01, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0);
        #1;
        n_tests++;
        if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_low got=%b want=0", iss_valid); end
        step();
        idle(); #1;
        n_tests++;
        if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got=%b want=1", disp_ready); end
        n_tests++;
        if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_dispatch got=%b want=0", iss_valid); end
    endtask

    task automatic test_cdb_wakeup();
        do_reset();
        disp_valid = 1'b1;
        disp_entry = mk(8'h31, 6'd5, 1'b0, 32'h0, 6'd0, 1'b0, 32'h55);
        step();
        idle(); cdb_in = '{valid: 1'b1, pd: 6'd5, rd_v: 32'hAB, rob_idx: '0};
        #1;
        n_tests++;
`ifdef RS_CDB_WAKEUP_ISSUE_EN
        if (iss_valid !== 1'b1 || iss_entry.ps1_val !== 32'hAB || iss_entry.ps2_val !== 32'h0) begin
            n_fail++; $display("FAIL wakeup_bypass got v=%b ps1=%h ps2=%h want v=1 ps1=ab ps2=0",
                               iss_valid, iss_entry.ps1_val, iss_entry.ps2_val);
        end
`else
        if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_no_bypass got=%b want=0", iss_valid); end
`endif
        step();
        cdb_in = '0; #1;
        n_tests++;
        if (iss_valid !== 1'b1 || iss_entry.ps1_val !== 32'hAB || iss_entry.ps2_val !== 32'h0
            || iss_entry.op !== 8'h31) begin
            n_fail++; $display("FAIL wakeup_issue got v=%b ps1=%h ps2=%h op=%h want v=1 ps1=ab ps2=0 op=31",
                               iss_valid, iss_entry.ps1_val, iss_entry.ps2_val, iss_entry.op);
        end
        fu_ready = 1'b1; step(); fu_ready = 1'b0; #1;
        n_tests++;
        if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_freed got=%b want=0", iss_valid); end
    endtask

    task automatic test_dispatch_capture();
        do_reset();
        disp_valid = 1'b1;
        disp_entry = mk(8'h32, 6'd7, 1'b0, 32'h0, 6'd3, 1'b1, 32'h22);
        cdb_in = '{valid: 1'b1, pd: 6'd7, rd_v: 32'h11, rob_idx: '0};
        step();
        idle(); #1;
        n_tests++;
        if (iss_valid !== 1'b1 || iss_entry.ps1_val !== 32'h11 || iss_entry.ps2_val !== 32'h22) begin
            n_fail++; $display("FAIL disp_capture got v=%b ps1=%h ps2=%h want v=1 ps1=11 ps2=22",
                               iss_valid, iss_entry.ps1_val, iss_entry.ps2_val);
        end
    endtask

    task automatic test_age_order();
        do_reset();
        disp_valid = 1'b1; disp_entry = mk(8'hA1, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2); step();
        disp_entry = mk(8'hB2, 6'd3, 1'b1, 32'h3, 6'd4, 1'b1, 32'h4); step();
        idle(); #1;
        n_tests++;
        if (iss_valid !== 1'b1 || iss_entry.op !== 8'hA1) begin
            n_fail++; $display("FAIL age_first got v=%b op=%h want v=1 op=a1", iss_valid, iss_entry.op);
        end
        step(); #1;
        n_tests++;
        if (iss_entry.op !== 8'hA1) begin n_fail++; $display("FAIL age_hold got op=%h want a1", iss_entry.op); end
        fu_ready = 1'b1; step(); #1;
        n_tests++;
        if (iss_valid !== 1'b1 || iss_entry.op !== 8'hB2) begin
            n_fail++; $display("FAIL age_second got v=%b op=%h want v=1 op=b2", iss_valid, iss_entry.op);
        end
        step(); #1;
        n_tests++;
        if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL age_drained got=%b want=0", iss_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            disp_valid = 1'b1;
            disp_entry = mk(8'(i), 6'd1, 1'b1, 32'(i), 6'd2, 1'b1, 32'h0);
            step();
        end
        idle(); #1;
        n_tests++;
        if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_not_ready got=%b want=0", disp_ready); end
        fu_ready = 1'b1; #1;
        n_tests++;
        if (disp_ready !== 1'b0 || iss_valid !== 1'b1 || iss_entry.op !== 8'd0) begin
            n_fail++; $display("FAIL full_issue_cycle got rdy=%b v=%b op=%h want rdy=0 v=1 op=0",
                               disp_ready, iss_valid, iss_entry.op);
        end
        step(); fu_ready = 1'b0; #1;
        n_tests++;
        if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed got=%b want=1", disp_ready); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            disp_valid = 1'b1;
            disp_entry = mk(8'(i), 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
            step();
        end
        idle(); flush = 1'b1; disp_valid = 1'b1; fu_ready = 1'b1;
        disp_entry = mk(8'h77, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
        cdb_in = '{valid: 1'b1, pd: 6'd9, rd_v: 32'h99, rob_idx: '0};
        #1;
        n_tests++;
        if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_iss_low got=%b want=0", iss_valid); end
        step();
        idle(); cdb_in = '{valid: 1'b1, pd: 6'd9, rd_v: 32'h99, rob_idx: '0}; #1;
        n_tests++;
        if (disp_ready !== 1'b1 || iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty got rdy=%b v=%b want rdy=1 v=0", disp_ready, iss_valid);
        end
        step(); cdb_in = '0; #1;
        n_tests++;
        if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_survivor got=%b want=0", iss_valid); end
    endtask

    task automatic test_tag0();
        do_reset();
        disp_valid = 1'b1;
        disp_entry = mk(8'h40, 6'd0, 1'b0, 32'hDEAD, 6'd4, 1'b0, 32'h0);
        step();
        idle(); cdb_in = '{valid: 1'b1, pd: 6'd0, rd_v: 32'hFF, rob_idx: '0};
        step(); cdb_in = '0; #1;
        n_tests++;
        if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL tag0_no_wake got=%b want=0", iss_valid); end
        cdb_in = '{valid: 1'b1, pd: 6'd4, rd_v: 32'h44, rob_idx: '0};
        step(); cdb_in = '0; #1;
        n_tests++;
        if (iss_valid !== 1'b1 || iss_entry.ps1_val !== 32'h0 || iss_entry.ps2_val !== 32'h44) begin
            n_fail++; $display("FAIL tag0_value got v=%b ps1=%h ps2=%h want v=1 ps1=0 ps2=44",
                               iss_valid, iss_entry.ps1_val, iss_entry.ps2_val);
        end
    endtask

    task automatic test_random();
        logic ev; rs_entry_t ee; int idx;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            flush      = ($urandom_range(0, 39) == 0);
            disp_valid = $urandom_range(0, 1);
            fu_ready   = ($urandom_range(0, 2) != 0);
            disp_entry = mk(8'($urandom), ptag_t'($urandom_range(0, 7)), 1'($urandom),
                            data_t'($urandom), ptag_t'($urandom_range(0, 7)), 1'($urandom),
                            data_t'($urandom));
            cdb_in.valid   = $urandom_range(0, 1);
            cdb_in.pd      = ptag_t'($urandom_range(0, 7));
            cdb_in.rd_v    = data_t'($urandom);
            cdb_in.rob_idx = rob_t'($urandom);
            #1;
            model_expect(ev, ee, idx);
            n_tests++;
            if (disp_ready !== (mq.size() < DEPTH)) begin
                n_fail++; $display("FAIL rand_disp_ready cyc=%0d got=%b want=%b", c, disp_ready, mq.size() < DEPTH);
            end
            n_tests++;
            if (iss_valid !== ev) begin
                n_fail++; $display("FAIL rand_iss_valid cyc=%0d got=%b want=%b", c, iss_valid, ev);
            end else if (ev && iss_entry !== ee) begin
                n_fail++; $display("FAIL rand_iss_entry cyc=%0d got=%h want=%h", c, iss_entry, ee);
            end
            step();
        end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_cdb_wakeup();
        test_dispatch_capture();
        test_age_order();
        test_full();
        test_flush();
        test_tag0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
